// File: rtl/rv_mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and the load/store path, with byte-lane steering and load extension.
// Define RV_MEM_ARB_TIMEOUT_EN to abort accesses that see no mem_ack within TIMEOUT cycles.
module rv_mem_arbiter #(
   parameter int unsigned MAX_D_BURST = 4,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [2:0]  d_op,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        d_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        busy
);

   // state  | meaning
   // IDLE   | no access in flight, arbitrating between IF and D
   // ACC_IF | fetch access on the memory port, waiting for mem_ack
   // ACC_D  | data access on the memory port; a rejected request spends one dead cycle here
   // RESP   | one-cycle ack (and err) pulse to the granted side
   typedef enum logic [1:0] {IDLE, ACC_IF, ACC_D, RESP} state_t;

   localparam logic [2:0] OP_B  = 3'b001;
   localparam logic [2:0] OP_H  = 3'b010;
   localparam logic [2:0] OP_W  = 3'b011;
   localparam logic [2:0] OP_BU = 3'b101;
   localparam logic [2:0] OP_HU = 3'b110;
   localparam logic [3:0] BURST_LIM = 4'(MAX_D_BURST);

   state_t      state_q, state_d;
   logic [3:0]  burst_q, burst_d;
   logic [2:0]  op_q, op_d;
   logic [1:0]  off_q, off_d;
   logic        rej_q, rej_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        if_ack_q, if_ack_d;
   logic        if_err_q, if_err_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic        d_ack_q, d_ack_d;
   logic        d_err_q, d_err_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        busy_q, busy_d;

   logic        d_op_ok, d_align_ok, d_bad, d_grant, end_acc;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [15:0] ld_shift;
   logic [31:0] ld_data;

`ifdef RV_MEM_ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);
   logic [7:0] tmo_q, tmo_d;
`else
   logic unused_tmo;
   assign unused_tmo = ^{8'(TIMEOUT)};
`endif

   logic unused_addr;
   assign unused_addr = ^if_addr[1:0];

   always_comb begin
      d_op_ok    = 1'b0;
      d_align_ok = 1'b1;
      case (d_op)
         OP_B, OP_BU: d_op_ok = 1'b1;
         OP_H, OP_HU: begin
            d_op_ok    = 1'b1;
            d_align_ok = ~d_addr[0];
         end
         OP_W: begin
            d_op_ok    = 1'b1;
            d_align_ok = (d_addr[1:0] == 2'b00);
         end
         default: d_op_ok = 1'b0;
      endcase
   end

   assign d_bad   = ~d_op_ok | ~d_align_ok;
   // IF only takes the port ahead of a pending D once D has used up its burst allowance.
   assign d_grant = d_req & ~(if_req & (burst_q == BURST_LIM));

   always_comb begin
      st_be    = 4'b0000;
      st_wdata = 32'h0;
      if (d_we) begin
         case (d_op)
            OP_B, OP_BU: begin
               st_be    = 4'b0001 << d_addr[1:0];
               st_wdata = {4{d_wdata[7:0]}};
            end
            OP_H, OP_HU: begin
               st_be    = 4'b0011 << d_addr[1:0];
               st_wdata = {2{d_wdata[15:0]}};
            end
            default: begin
               st_be    = 4'b1111;
               st_wdata = d_wdata;
            end
         endcase
      end
   end

   always_comb begin
      ld_shift = 16'(mem_rdata >> {off_q, 3'b000});
      case (op_q)
         OP_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         OP_BU:   ld_data = {24'h0, ld_shift[7:0]};
         OP_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         OP_HU:   ld_data = {16'h0, ld_shift[15:0]};
         default: ld_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      burst_d     = burst_q;
      op_d        = op_q;
      off_d       = off_q;
      rej_d       = rej_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      if_ack_d    = 1'b0;
      if_err_d    = 1'b0;
      if_rdata_d  = 32'h0;
      d_ack_d     = 1'b0;
      d_err_d     = 1'b0;
      d_rdata_d   = 32'h0;
      end_acc     = 1'b0;
`ifdef RV_MEM_ARB_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef RV_MEM_ARB_TIMEOUT_EN
            tmo_d = TMO_LOAD;
`endif
            if (d_grant) begin
               burst_d = if_req ? ((burst_q == 4'hF) ? burst_q : burst_q + 4'd1) : 4'd0;
               op_d    = d_op;
               off_d   = d_addr[1:0];
               rej_d   = d_bad;
               state_d = ACC_D;
               if (!d_bad) begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = d_we;
                  mem_addr_d  = {d_addr[31:2], 2'b00};
                  mem_be_d    = st_be;
                  mem_wdata_d = st_wdata;
               end
            end else if (if_req) begin
               burst_d     = 4'd0;
               state_d     = ACC_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = {if_addr[31:2], 2'b00};
               mem_be_d    = 4'b0000;
               mem_wdata_d = 32'h0;
            end
         end
         ACC_IF: begin
            if (mem_ack) begin
               end_acc    = 1'b1;
               if_ack_d   = 1'b1;
               if_rdata_d = mem_rdata;
            end
`ifdef RV_MEM_ARB_TIMEOUT_EN
            else if (tmo_q == 8'd0) begin
               end_acc  = 1'b1;
               if_ack_d = 1'b1;
               if_err_d = 1'b1;
            end else begin
               tmo_d = tmo_q - 8'd1;
            end
`endif
         end
         ACC_D: begin
            // Rejected requests still take the full two-cycle latency, but never touch memory.
            if (rej_q) begin
               end_acc = 1'b1;
               d_ack_d = 1'b1;
               d_err_d = 1'b1;
               rej_d   = 1'b0;
            end else if (mem_ack) begin
               end_acc   = 1'b1;
               d_ack_d   = 1'b1;
               d_rdata_d = mem_we_q ? 32'h0 : ld_data;
            end
`ifdef RV_MEM_ARB_TIMEOUT_EN
            else if (tmo_q == 8'd0) begin
               end_acc = 1'b1;
               d_ack_d = 1'b1;
               d_err_d = 1'b1;
            end else begin
               tmo_d = tmo_q - 8'd1;
            end
`endif
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (end_acc) begin
         state_d     = RESP;
         mem_req_d   = 1'b0;
         mem_we_d    = 1'b0;
         mem_addr_d  = 32'h0;
         mem_be_d    = 4'b0000;
         mem_wdata_d = 32'h0;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         burst_q     <= 4'd0;
         op_q        <= 3'b000;
         off_q       <= 2'b00;
         rej_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_be_q    <= 4'b0000;
         mem_wdata_q <= 32'h0;
         if_ack_q    <= 1'b0;
         if_err_q    <= 1'b0;
         if_rdata_q  <= 32'h0;
         d_ack_q     <= 1'b0;
         d_err_q     <= 1'b0;
         d_rdata_q   <= 32'h0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         burst_q     <= burst_d;
         op_q        <= op_d;
         off_q       <= off_d;
         rej_q       <= rej_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         if_err_q    <= if_err_d;
         if_rdata_q  <= if_rdata_d;
         d_ack_q     <= d_ack_d;
         d_err_q     <= d_err_d;
         d_rdata_q   <= d_rdata_d;
         busy_q      <= busy_d;
      end
   end

`ifdef RV_MEM_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_q <= 8'd0;
      else        tmo_q <= tmo_d;
   end
`endif

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign if_ack    = if_ack_q;
   assign if_err    = if_err_q;
   assign if_rdata  = if_rdata_q;
   assign d_ack     = d_ack_q;
   assign d_err     = d_err_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed self-checking bench for rv_mem_arbiter; inputs change and outputs are sampled on the falling clock edge.
module tb_rv_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack, if_err;
   logic        d_req, d_we;
   logic [2:0]  d_op;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        d_ack, d_err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        busy;
   logic        ack_en, ack_force;

   int total = 0;
   int bad   = 0;

   // zero-wait memory: acks in the same cycle as mem_req when enabled
   assign mem_ack = ack_force | (ack_en & mem_req);

   always #5 clk = ~clk;

   rv_mem_arbiter #(.MAX_D_BURST(4), .TIMEOUT(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
   );

   a_d_hold: assert property (@(posedge clk) disable iff (!rst_n) (d_req && !d_ack) |=> (d_req || d_ack))
      else $error("d_req dropped before d_ack");
   a_if_hold: assert property (@(posedge clk) disable iff (!rst_n) (if_req && !if_ack) |=> (if_req || if_ack))
      else $error("if_req dropped before if_ack");

   task automatic test_reset();
      logic seen;
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({if_rdata, if_ack, if_err, d_rdata, d_ack, d_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy} !== '0) begin
         bad++; $display("FAIL reset_outputs: got req=%b busy=%b addr=%h be=%b wdata=%h want all zero", mem_req, busy, mem_addr, mem_be, mem_wdata);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      ack_en = 1'b0;
      d_req = 1'b1; d_we = 1'b1; d_op = 3'b011; d_addr = 32'h0000_0040; d_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1111 || mem_wdata !== 32'hCAFE_F00D) begin
         bad++; $display("FAIL reset_pre_access: got req=%b busy=%b we=%b be=%b wdata=%h want 1 1 1 1111 cafef00d", mem_req, busy, mem_we, mem_be, mem_wdata);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy, d_ack} !== '0) begin
         bad++; $display("FAIL reset_async: got req=%b we=%b addr=%h be=%b busy=%b want all zero", mem_req, mem_we, mem_addr, mem_be, busy);
      end
      d_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ack_force = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (d_ack || if_ack || busy || mem_req) seen = 1'b1;
      end
      ack_force = 1'b0;
      total++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL reset_stray_ack: got activity=%b want 0", seen);
      end
      ack_en = 1'b1;
   endtask

   task automatic test_fetch();
      mem_rdata = 32'h0051_8193;
      if_req = 1'b1; if_addr = 32'h0000_1003;
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_we !== 1'b0 || mem_be !== 4'b0000 || busy !== 1'b1) begin
         bad++; $display("FAIL fetch_access: got req=%b addr=%h we=%b be=%b busy=%b want 1 00001000 0 0000 1", mem_req, mem_addr, mem_we, mem_be, busy);
      end
      @(negedge clk);
      total++;
      if (if_ack !== 1'b1 || if_err !== 1'b0 || if_rdata !== 32'h0051_8193 || mem_req !== 1'b0 || d_ack !== 1'b0) begin
         bad++; $display("FAIL fetch_ack: got ack=%b err=%b rdata=%h req=%b want 1 0 00518193 0", if_ack, if_err, if_rdata, mem_req);
      end
      if_req = 1'b0;
      @(negedge clk);
      total++;
      if (if_ack !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL fetch_idle: got ack=%b busy=%b want 0 0", if_ack, busy);
      end
   endtask

   task automatic test_load_ext();
      logic [2:0]  op_t  [8] = '{3'b001, 3'b101, 3'b010, 3'b110, 3'b001, 3'b010, 3'b011, 3'b101};
      logic [31:0] adr_t [8] = '{32'h2003, 32'h2003, 32'h2002, 32'h2002, 32'h2000, 32'h2000, 32'h2004, 32'h2001};
      logic [31:0] exp_t [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                                 32'h0000_0034, 32'h0000_1234, 32'h80FF_1234, 32'h0000_0012};
      logic [31:0] wa;
      mem_rdata = 32'h80FF_1234;
      for (int i = 0; i < 8; i++) begin
         d_req = 1'b1; d_we = 1'b0; d_op = op_t[i]; d_addr = adr_t[i]; d_wdata = 32'hFFFF_FFFF;
         wa = adr_t[i] & 32'hFFFF_FFFC;
         @(negedge clk);
         total++;
         if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b0000 || mem_addr !== wa || d_ack !== 1'b0) begin
            bad++; $display("FAIL load%0d_access: got req=%b we=%b be=%b addr=%h ack=%b want 1 0 0000 %h 0", i, mem_req, mem_we, mem_be, mem_addr, d_ack, wa);
         end
         @(negedge clk);
         total++;
         if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== exp_t[i]) begin
            bad++; $display("FAIL load%0d_data: got ack=%b err=%b rdata=%h want 1 0 %h", i, d_ack, d_err, d_rdata, exp_t[i]);
         end
         d_req = 1'b0;
         @(negedge clk);
         total++;
         if (d_ack !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL load%0d_idle: got ack=%b busy=%b want 0 0", i, d_ack, busy);
         end
      end
   endtask

   task automatic test_store();
      logic [2:0]  op_t [5] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b001};
      logic [31:0] ad_t [5] = '{32'h3002, 32'h3001, 32'h3008, 32'h3000, 32'h3003};
      logic [31:0] wd_t [5] = '{32'h1234_BEEF, 32'h7777_77AB, 32'hDEAD_BEEF, 32'h0000_5A5A, 32'h0000_00C3};
      logic [3:0]  be_t [5] = '{4'b1100, 4'b0010, 4'b1111, 4'b0011, 4'b1000};
      logic [31:0] mw_t [5] = '{32'hBEEF_BEEF, 32'hABAB_ABAB, 32'hDEAD_BEEF, 32'h5A5A_5A5A, 32'hC3C3_C3C3};
      logic [31:0] wa;
      for (int i = 0; i < 5; i++) begin
         d_req = 1'b1; d_we = 1'b1; d_op = op_t[i]; d_addr = ad_t[i]; d_wdata = wd_t[i];
         wa = ad_t[i] & 32'hFFFF_FFFC;
         @(negedge clk);
         total++;
         if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== wa || mem_be !== be_t[i] || mem_wdata !== mw_t[i]) begin
            bad++; $display("FAIL store%0d_lanes: got req=%b we=%b addr=%h be=%b wdata=%h want 1 1 %h %b %h",
                            i, mem_req, mem_we, mem_addr, mem_be, mem_wdata, wa, be_t[i], mw_t[i]);
         end
         @(negedge clk);
         total++;
         if (d_ack !== 1'b1 || d_err !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL store%0d_ack: got ack=%b err=%b req=%b want 1 0 0", i, d_ack, d_err, mem_req);
         end
         d_req = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_errors();
      logic        we_t [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [2:0]  op_t [7] = '{3'b011, 3'b010, 3'b010, 3'b111, 3'b000, 3'b100, 3'b011};
      logic [31:0] ad_t [7] = '{32'h6, 32'h5, 32'h3, 32'h0, 32'h0, 32'h8, 32'h2};
      int reqs;
      for (int i = 0; i < 7; i++) begin
         reqs = 0;
         d_req = 1'b1; d_we = we_t[i]; d_op = op_t[i]; d_addr = ad_t[i]; d_wdata = 32'h1111_2222;
         @(negedge clk);
         if (mem_req !== 1'b0) reqs++;
         total++;
         if (d_ack !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL err%0d_wait: got ack=%b busy=%b want 0 1", i, d_ack, busy);
         end
         @(negedge clk);
         if (mem_req !== 1'b0) reqs++;
         total++;
         if (d_ack !== 1'b1 || d_err !== 1'b1 || reqs != 0) begin
            bad++; $display("FAIL err%0d_resp: got ack=%b err=%b mem_req_cycles=%0d want 1 1 0", i, d_ack, d_err, reqs);
         end
         d_req = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  op_t  [3] = '{3'b001, 3'b110, 3'b011};
      logic [31:0] ad_t  [3] = '{32'h4003, 32'h4002, 32'h4000};
      logic [31:0] exp_t [3] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'h80FF_1234};
      int idx = 0;
      int gap = 0;
      mem_rdata = 32'h80FF_1234;
      d_req = 1'b1; d_we = 1'b0; d_op = op_t[0]; d_addr = ad_t[0];
      for (int c = 0; c < 15 && idx < 3; c++) begin
         @(negedge clk);
         gap++;
         if (d_ack) begin
            total++;
            if (gap != ((idx == 0) ? 2 : 3) || d_rdata !== exp_t[idx]) begin
               bad++; $display("FAIL b2b%0d: got gap=%0d rdata=%h want gap=%0d rdata=%h", idx, gap, d_rdata, (idx == 0) ? 2 : 3, exp_t[idx]);
            end
            idx++;
            gap = 0;
            if (idx < 3) begin
               d_op = op_t[idx]; d_addr = ad_t[idx];
            end else begin
               d_req = 1'b0;
            end
         end
      end
      total++;
      if (idx != 3) begin
         bad++; d_req = 1'b0; $display("FAIL b2b_count: got acks=%0d want 3", idx);
      end
      @(negedge clk);
   endtask

   task automatic test_fairness();
      logic exp_if [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int n = 0;
      logic got_d;
      mem_rdata = 32'h1357_9BDF;
      if_req = 1'b1; if_addr = 32'h0000_0100;
      d_req = 1'b1; d_we = 1'b0; d_op = 3'b011; d_addr = 32'h0000_0200;
      for (int c = 0; c < 60 && n < 10; c++) begin
         @(negedge clk);
         if (if_ack || d_ack) begin
            total++;
            if (if_ack !== exp_if[n] || d_ack !== !exp_if[n]) begin
               bad++; $display("FAIL fair_grant%0d: got if_ack=%b d_ack=%b want if_ack=%b", n, if_ack, d_ack, exp_if[n]);
            end
            n++;
         end
      end
      total++;
      if (n != 10) begin
         bad++; $display("FAIL fair_count: got acks=%0d want 10", n);
      end
      if_req = 1'b0;
      got_d = 1'b0;
      for (int c = 0; c < 8 && !got_d; c++) begin
         @(negedge clk);
         if (d_ack) got_d = 1'b1;
      end
      total++;
      if (got_d !== 1'b1 || d_rdata !== 32'h1357_9BDF) begin
         bad++; $display("FAIL fair_tail: got d_ack_seen=%b rdata=%h want 1 13579bdf", got_d, d_rdata);
      end
      d_req = 1'b0;
      @(negedge clk);
   endtask

`ifdef RV_MEM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int req_cycles = 0;
      logic seen = 1'b0;
      ack_en = 1'b0;
      if_req = 1'b1; if_addr = 32'h0000_0500;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (mem_req) req_cycles++;
         if (if_ack) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b1 || req_cycles != 10) begin
         bad++; $display("FAIL tmo_length: got ack_seen=%b mem_req_cycles=%0d want 1 10", seen, req_cycles);
      end
      total++;
      if (if_err !== 1'b1 || if_rdata !== 32'h0 || mem_req !== 1'b0) begin
         bad++; $display("FAIL tmo_abort: got err=%b rdata=%h req=%b want 1 0 0", if_err, if_rdata, mem_req);
      end
      if_req = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || if_ack !== 1'b0) begin
         bad++; $display("FAIL tmo_idle: got busy=%b ack=%b want 0 0", busy, if_ack);
      end
      ack_en = 1'b1;
   endtask
`else
   task automatic test_timeout();
      int acks = 0;
      ack_en = 1'b0;
      if_req = 1'b1; if_addr = 32'h0000_0500;
      repeat (300) begin
         @(negedge clk);
         if (if_ack) acks++;
      end
      total++;
      if (acks != 0 || mem_req !== 1'b1 || busy !== 1'b1 || if_err !== 1'b0) begin
         bad++; $display("FAIL notmo_wait: got acks=%0d req=%b busy=%b err=%b want 0 1 1 0", acks, mem_req, busy, if_err);
      end
      #2 rst_n = 1'b0;
      #1;
      if_req = 1'b0;
      total++;
      if (mem_req !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL notmo_reset: got req=%b busy=%b want 0 0", mem_req, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ack_en = 1'b1;
      @(negedge clk);
   endtask
`endif

   initial begin
      rst_n = 1'b1;
      if_req = 1'b0; if_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_op = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;
      mem_rdata = 32'h0;
      ack_en = 1'b1; ack_force = 1'b0;
      test_reset();
      test_fetch();
      test_load_ext();
      test_store();
      test_errors();
      test_back_to_back();
      test_fairness();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
